// File: rtl/f8_ifetch.sv
// f8_ifetch: instruction-fetch responder for the CPU instruction port.
// Assembles the unaligned 3-byte window at iread_addr from a 16-bit,
// little-endian backing memory. Two tagged word slots let sequential
// execution hit with zero latency. At most one memory read is outstanding.
module f8_ifetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] iread_addr,
  output logic [23:0] iread_data,
  output logic        ivalid,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);

  typedef enum logic {
    ST_IDLE,  // no read outstanding
    ST_WAIT   // one read outstanding, tag held in rt_q
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [14:0] tag;
    logic [15:0] data;
  } slot_t;

  state_t      state_q, state_d;
  slot_t       slot_q [2];
  logic [14:0] rt_q;

  // Word addresses covering the window; wh wraps at the top of memory.
  logic [14:0] wl, wh;
  logic        hit_wl, hit_wh;
  logic [15:0] wl_data, wh_data;
  logic [31:0] window;
  logic [1:0]  slot_free;
  logic        store_en;

  // Tag compare and byte assembly for the requested window.
  always_comb begin
    wl      = iread_addr[15:1];
    wh      = wl + 15'd1;
    hit_wl  = (slot_q[0].valid && slot_q[0].tag == wl) ||
              (slot_q[1].valid && slot_q[1].tag == wl);
    hit_wh  = (slot_q[0].valid && slot_q[0].tag == wh) ||
              (slot_q[1].valid && slot_q[1].tag == wh);
    wl_data = (slot_q[0].valid && slot_q[0].tag == wl) ? slot_q[0].data : slot_q[1].data;
    wh_data = (slot_q[0].valid && slot_q[0].tag == wh) ? slot_q[0].data : slot_q[1].data;
    window  = {wh_data, wl_data};
    ivalid  = !reset && hit_wl && hit_wh;
    if (!ivalid)
      iread_data = 24'h000000;
    else if (iread_addr[0])
      iread_data = window[31:8];
    else
      iread_data = window[23:0];
  end

  // Pick where a returning word may land: empty slots or slots whose word
  // is no longer part of the current window. A response for a word outside
  // the current window is dropped.
  always_comb begin
    for (int i = 0; i < 2; i++)
      slot_free[i] = !slot_q[i].valid || (slot_q[i].tag != wl && slot_q[i].tag != wh);
    store_en = (state_q == ST_WAIT) && mem_rvalid && (rt_q == wl || rt_q == wh);
  end

  // Next-state and read-request logic; the low word is fetched first.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_addr = rt_q;
    if (reset) begin
      mem_addr = 15'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_addr = wl;
          if (!hit_wl) begin
            mem_rd  = 1'b1;
            state_d = ST_WAIT;
          end else if (!hit_wh) begin
            mem_rd   = 1'b1;
            mem_addr = wh;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register, outstanding tag and slot updates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q <= ST_IDLE;
      rt_q    <= 15'd0;
      // NOTE: the slot array is tiny and must come up invalid, so it is reset
      // explicitly rather than left to power-up contents.
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (mem_rd) rt_q <= mem_addr;
      if (store_en) begin
        if (slot_free[0])
          slot_q[0] <= '{valid: 1'b1, tag: rt_q, data: mem_rdata};
        else if (slot_free[1])
          slot_q[1] <= '{valid: 1'b1, tag: rt_q, data: mem_rdata};
      end
    end
  end

endmodule
